// File: rtl/soc_pkg.sv
// soc_pkg: shared widths and FSM state type for the flash read path.
package soc_pkg;
  localparam int FLASH_ADDR_W = 24;
  localparam int WORD_W = 32;
  typedef enum logic [2:0] {IDLE, LOOKUP, ISSUE, WAIT_DONE, RESPOND} fa_state_t;
endpackage

// File: rtl/flash_arbiter_if.sv
// flash_arbiter_if: requester-side and flash-engine-side signal bundles.
interface flash_req_if import soc_pkg::*; #(parameter int ADDR_W = FLASH_ADDR_W);
  logic [1:0] req_valid;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [1:0] req_ready;
  logic [WORD_W-1:0] req_rdata;
  modport master (output req_valid, req_addr0, req_addr1, input req_ready, req_rdata);
  modport slave (input req_valid, req_addr0, req_addr1, output req_ready, req_rdata);
endinterface

interface flash_sfr_if import soc_pkg::*; #(parameter int ADDR_W = FLASH_ADDR_W);
  logic sfr_start;
  logic [ADDR_W-1:0] sfr_address;
  logic [ADDR_W-1:0] sfr_word_count;
  logic sfr_strobe;
  logic sfr_done;
  logic [WORD_W-1:0] sfr_data;
  modport master (output sfr_start, sfr_address, sfr_word_count, input sfr_strobe, sfr_done, sfr_data);
  modport slave (input sfr_start, sfr_address, sfr_word_count, output sfr_strobe, sfr_done, sfr_data);
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; the pointer names the requester
// favoured on the next contention and always moves to the loser.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic       o_gnt
);
  logic r_ptr;
  assign o_gnt = &i_req ? r_ptr : i_req[1];
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) r_ptr <= 1'b0;
    else if (i_advance) r_ptr <= ~o_gnt;
endmodule

// File: rtl/flash_arbiter.sv
// flash_arbiter: arbitrates two word-read requesters onto a single flash read
// engine, with a one-entry cache holding the last word fetched.
module flash_arbiter import soc_pkg::*; #(
  parameter bit CACHE_EN = 1'b1,
  parameter int ADDR_W   = FLASH_ADDR_W
) (
  input logic         clk,
  input logic         n_reset,
  input logic         cache_inval,
  flash_req_if.slave  req,
  flash_sfr_if.master sfr
);
  fa_state_t r_state;
  logic r_gnt, r_start, r_cv;
  logic [1:0] r_ready;
  logic [ADDR_W-1:0] r_addr, r_sfr_addr, r_tag;
  logic [WORD_W-1:0] r_word, r_cdata, r_rdata;
  logic w_gnt, w_take, w_hit;
  logic [ADDR_W-1:0] w_req_addr;

  assign w_take     = (r_state == IDLE) && |req.req_valid;
  assign w_req_addr = w_gnt ? req.req_addr1 : req.req_addr0;
  assign w_hit      = CACHE_EN && r_cv && (r_tag == r_addr);

  rr_arbiter2 u_rr (.clk, .n_reset, .i_req(req.req_valid), .i_advance(w_take), .o_gnt(w_gnt));

  // ready/rdata are registered so they are exactly one cycle wide and zero elsewhere
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      r_state    <= IDLE;
      r_gnt      <= 1'b0;
      r_addr     <= '0;
      r_sfr_addr <= '0;
      r_start    <= 1'b0;
      r_word     <= '0;
      r_ready    <= '0;
      r_rdata    <= '0;
    end else begin
      r_ready <= '0;
      r_rdata <= '0;
      case (r_state)
        IDLE: if (w_take) begin
          r_gnt   <= w_gnt;
          r_addr  <= w_req_addr & ~ADDR_W'(3);
          r_state <= LOOKUP;
        end
        LOOKUP: if (w_hit) begin
          r_ready[r_gnt] <= 1'b1;
          r_rdata        <= r_cdata;
          r_state        <= RESPOND;
        end else begin
          r_start    <= 1'b1;
          r_sfr_addr <= r_addr;
          r_state    <= ISSUE;
        end
        ISSUE: if (sfr.sfr_strobe) begin
          r_word  <= sfr.sfr_data;
          r_start <= 1'b0;
          r_state <= WAIT_DONE;
        end
        WAIT_DONE: if (sfr.sfr_done) begin
          r_ready[r_gnt] <= 1'b1;
          r_rdata        <= r_word;
          r_state        <= RESPOND;
        end
        RESPOND: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end

  // invalidate takes priority over a fill landing on the same edge
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      r_cv    <= 1'b0;
      r_tag   <= '0;
      r_cdata <= '0;
    end else if (cache_inval) r_cv <= 1'b0;
    else if (CACHE_EN && r_state == ISSUE && sfr.sfr_strobe) begin
      r_cv    <= 1'b1;
      r_tag   <= r_addr;
      r_cdata <= sfr.sfr_data;
    end

  assign req.req_ready      = r_ready;
  assign req.req_rdata      = r_rdata;
  assign sfr.sfr_start      = r_start;
  assign sfr.sfr_address    = r_sfr_addr;
  assign sfr.sfr_word_count = ADDR_W'(1);
endmodule

// File: tb/tb_flash_arbiter.sv
// tb_flash_arbiter: directed and randomized reads checked against a
// transaction-level model of arbitration order, cache contents and latency.
module tb_flash_arbiter;
  import soc_pkg::*;
  logic clk = 1'b0, n_reset = 1'b0, inval_now = 1'b0, inval_arm = 1'b0;
  logic cache_inval0;
  always #5 clk = ~clk;

  flash_req_if q0();
  flash_sfr_if s0();
  flash_req_if q1();
  flash_sfr_if s1();
  assign cache_inval0 = inval_now | (inval_arm & s0.sfr_strobe);

  flash_arbiter #(.CACHE_EN(1'b1)) u0 (.clk(clk), .n_reset(n_reset), .cache_inval(cache_inval0), .req(q0), .sfr(s0));
  flash_arbiter #(.CACHE_EN(1'b0)) u1 (.clk(clk), .n_reset(n_reset), .cache_inval(1'b0), .req(q1), .sfr(s1));

  int n_chk = 0, n_pass = 0, n_fail = 0, cyc = 0;
  int n_start0 = 0, n_start1 = 0, e_ph = 0, e_cnt = 0, e_lat = 0, e_cyc = 0;
  logic [31:0] e_data = '0, e_fval = '0;
  bit e_fv = 1'b0;
  bit m_ptr = 1'b0, m_cv = 1'b0;
  logic [23:0] m_tag = '0;
  logic [31:0] m_cd = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // flash engine for u0: random strobe delay and random done-low tail
  always @(negedge clk) begin
    if (!n_reset) begin
      e_ph = 0;
      s0.sfr_strobe = 1'b0;
      s0.sfr_done = 1'b1;
    end else if (e_ph == 0) begin
      if (s0.sfr_start) begin
        n_start0++;
        e_ph = 1;
        e_cnt = $urandom_range(0, 3);
        s0.sfr_done = 1'b0;
      end
    end else if (e_ph == 1) begin
      if (e_cnt > 0) e_cnt--;
      else begin
        e_data = e_fv ? e_fval : $urandom;
        s0.sfr_data = e_data;
        s0.sfr_strobe = 1'b1;
        s0.sfr_done = 1'($urandom_range(0, 1));
        e_cyc = cyc;
        e_cnt = $urandom_range(0, 2);
        e_lat = 2 + e_cnt;
        e_ph = 2;
      end
    end else begin
      s0.sfr_strobe = 1'b0;
      if (e_cnt > 0) begin
        e_cnt--;
        s0.sfr_done = 1'b0;
      end else begin
        s0.sfr_done = 1'b1;
        e_ph = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!n_reset) begin
      s1.sfr_strobe = 1'b0;
      s1.sfr_done = 1'b1;
    end else if (s1.sfr_strobe) s1.sfr_strobe = 1'b0;
    else if (s1.sfr_start) begin
      n_start1++;
      s1.sfr_data = 32'h0BAD_0000 + 32'(n_start1);
      s1.sfr_strobe = 1'b1;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    n_reset = 1'b0;
    q0.req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    m_ptr = 1'b0;
    m_cv = 1'b0;
  endtask

  task automatic txn(input logic [1:0] m, input logic [23:0] a0, input logic [23:0] a1, input bit drop);
    logic [1:0] pend;
    logic [23:0] w;
    int t, s_mark;
    bit g, hit;
    @(negedge clk);
    q0.req_addr0 = a0;
    q0.req_addr1 = a1;
    q0.req_valid = m;
    pend = m;
    s_mark = n_start0;
    t = 0;
    while (pend != 2'b00 && t < 100) begin
      @(negedge clk);
      t++;
      if (drop && t == 1) q0.req_valid = 2'b00;
      if (q0.req_ready == 2'b00) check("rdata_idle", q0.req_rdata, 32'h0);
      else begin
        g = (pend == 2'b11) ? m_ptr : pend[1];
        w = (g ? a1 : a0) & 24'hFFFFFC;
        hit = m_cv && (m_tag == w);
        check("ready_onehot", 32'(q0.req_ready), 32'(2'b01 << g));
        check("starts_issued", n_start0 - s_mark, hit ? 0 : 1);
        if (hit) begin
          check("hit_data", q0.req_rdata, m_cd);
          if (m != 2'b11) check("hit_latency", t, 2);
        end else begin
          check("miss_data", q0.req_rdata, e_data);
          check("sfr_address", 32'(s0.sfr_address), 32'(w));
          check("miss_latency", cyc - e_cyc, e_lat);
          if (inval_arm) m_cv = 1'b0;
          else begin
            m_cv = 1'b1;
            m_tag = w;
            m_cd = e_data;
          end
        end
        m_ptr = !g;
        pend[g] = 1'b0;
        s_mark = n_start0;
        if (!drop) q0.req_valid = pend;
      end
    end
    check("txn_complete", 32'(pend), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int t;
    q0.req_valid = 2'b00;
    q0.req_addr0 = '0;
    q0.req_addr1 = '0;
    q1.req_valid = 2'b00;
    q1.req_addr0 = '0;
    q1.req_addr1 = '0;
    @(negedge clk);
    check("rst_ready", 32'(q0.req_ready), 32'h0);
    check("rst_rdata", q0.req_rdata, 32'h0);
    check("rst_start", 32'(s0.sfr_start), 32'h0);
    check("rst_address", 32'(s0.sfr_address), 32'h0);
    check("word_count", 32'(s0.sfr_word_count), 32'h1);
    @(negedge clk);
    n_reset = 1'b1;
    // single miss, then a hit on another byte of the same word
    e_fv = 1'b1;
    e_fval = 32'hDEADBEEF;
    txn(2'b01, 24'h000104, 24'h0, 1'b0);
    txn(2'b01, 24'h000106, 24'h0, 1'b0);
    // contention straight after reset, then a pair after a lone req0
    do_reset();
    e_fv = 1'b0;
    txn(2'b11, 24'h000010, 24'h000020, 1'b0);
    txn(2'b01, 24'h000300, 24'h0, 1'b0);
    txn(2'b11, 24'h000010, 24'h000020, 1'b0);
    // invalidate coinciding with the fill
    e_fv = 1'b1;
    e_fval = 32'hCAFEF00D;
    inval_arm = 1'b1;
    txn(2'b01, 24'h000040, 24'h0, 1'b0);
    inval_arm = 1'b0;
    e_fv = 1'b0;
    txn(2'b01, 24'h000040, 24'h0, 1'b0);
    txn(2'b10, 24'h0, 24'h000044, 1'b1);
    // reset while a flash read is in flight
    @(negedge clk);
    q0.req_addr0 = 24'h000500;
    q0.req_valid = 2'b01;
    t = 0;
    while (!s0.sfr_start && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("start_before_reset", 32'(s0.sfr_start), 32'h1);
    #2 n_reset = 1'b0;
    #1;
    check("reset_start_drop", 32'(s0.sfr_start), 32'h0);
    check("reset_ready", 32'(q0.req_ready), 32'h0);
    check("reset_address", 32'(s0.sfr_address), 32'h0);
    q0.req_valid = 2'b00;
    m_ptr = 1'b0;
    m_cv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    txn(2'b01, 24'h000044, 24'h0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      logic [1:0] m;
      bit d;
      m = 2'($urandom_range(1, 3));
      d = (m != 2'b11) && ($urandom_range(0, 4) == 0);
      inval_arm = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 6) == 0) begin
        @(negedge clk);
        inval_now = 1'b1;
        @(negedge clk);
        inval_now = 1'b0;
        m_cv = 1'b0;
      end
      txn(m, 24'h000200 + 24'($urandom_range(0, 15)), 24'h000200 + 24'($urandom_range(0, 15)), d);
    end
    inval_arm = 1'b0;
    // cache disabled: repeated reads of one word always go to flash
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      q1.req_addr0 = 24'h000080;
      q1.req_valid = 2'b01;
      t = 0;
      while (q1.req_ready == 2'b00 && t < 50) begin
        @(negedge clk);
        t++;
      end
      check("nocache_ready", 32'(q1.req_ready), 32'h1);
      check("nocache_data", q1.req_rdata, 32'h0BAD_0000 + 32'(k + 1));
      q1.req_valid = 2'b00;
    end
    check("nocache_starts", n_start1, 2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/flash_arbiter.md
FLASH_ARBITER -- requirements
Module: flash_arbiter

Interface
REQ-001 Parameter CACHE_EN, default 1, SHALL enable the one-entry last-word read cache; 0 forces every request to miss.
REQ-002 Parameter ADDR_W, default 24, SHALL set the flash byte-address width.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 n_reset  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  2  per-requester read request, held until matching req_ready.
REQ-006 req_addr0, req_addr1  input  ADDR_W each  byte address, stable while req_valid high.
REQ-007 req_ready  output  2  one-cycle pulse completing the granted request.
REQ-008 req_rdata  output  32  read word, valid while any req_ready bit high.
REQ-009 cache_inval  input  1  clears the cache entry.
REQ-010 sfr_start  output  1  level request to flash read engine.
REQ-011 sfr_address  output  ADDR_W  word-aligned flash address.
REQ-012 sfr_word_count  output  ADDR_W  constant 1.
REQ-013 sfr_strobe  input  1  engine data-valid pulse.
REQ-014 sfr_done  input  1  engine idle / transfer complete.
REQ-015 sfr_data  input  32  engine read data, valid with sfr_strobe.

Function
REQ-016 FSM states SHALL be IDLE, LOOKUP, ISSUE, WAIT_DONE, RESPOND.
REQ-017 IDLE: when any req_valid bit is high, SHALL grant one requester, register grant id and {addr[ADDR_W-1:2],2'b00}, and move to LOOKUP.
REQ-018 Arbitration SHALL be round-robin: both valid -> requester pointed to by rr_ptr wins; single valid -> that requester wins; rr_ptr then points to the non-granted requester.
REQ-019 LOOKUP: cache valid and tag equal to registered word address -> RESPOND, else ISSUE.
REQ-020 ISSUE: sfr_start SHALL be high and sfr_address driven; on sfr_strobe capture sfr_data, write cache tag/data/valid, drop sfr_start the following cycle, go to WAIT_DONE.
REQ-021 WAIT_DONE: exit to RESPOND on sfr_done=1; done sampled high in the strobe cycle SHALL NOT be used (engine still busy).
REQ-022 RESPOND: req_ready[grant]=1 for exactly one cycle with req_rdata = captured or cached word, then IDLE.
REQ-023 Latency SHALL be: hit, ready 2 cycles after valid sampled in IDLE; miss, strobe cycle + 2 minimum.
REQ-024 req_rdata SHALL be 0 outside RESPOND.
REQ-025 cache_inval SHALL clear cache valid next edge; simultaneous with strobe capture, invalidate wins (entry left invalid, current response still returns sfr_data).
REQ-026 req_valid dropped mid-transaction (protocol violation) SHALL NOT abort; transaction completes and the ready pulse is still issued.
REQ-027 Only one flash transaction SHALL be outstanding; the non-granted requester waits with no starvation beyond one transaction.

Reset
REQ-028 n_reset low SHALL immediately force: state IDLE, rr_ptr 0, cache valid 0, req_ready 0, req_rdata 0, sfr_start 0, sfr_address 0.
REQ-029 Reset mid-ISSUE SHALL drop sfr_start asynchronously; the engine is reset by the same n_reset.

Structure
REQ-030 Shared package soc_pkg SHALL hold the FSM state enum, FLASH_ADDR_W=24 and WORD_W=32.
REQ-031 Round-robin grant logic SHALL be the sub-module rr_arbiter2 (req[1:0], advance -> grant id, rr_ptr register).
REQ-032 Cache tag/data/valid registers SHALL live in flash_arbiter, no RAM macro.

Verification
REQ-033 Req0 addr 0x000104, engine returns 0xDEADBEEF -> sfr_address 0x000104, req_ready=2'b01 one cycle, rdata 0xDEADBEEF.
REQ-034 Repeat req0 addr 0x000106 -> hit, no sfr_start, ready 2 cycles after valid, rdata 0xDEADBEEF.
REQ-035 Both valid at same cycle after reset (0x10, 0x20) -> req0 served first, then req1; third back-to-back pair served req1 first.
REQ-036 cache_inval pulsed same cycle as strobe for 0x40 -> response 0xCAFEF00D delivered, next read 0x40 misses and issues sfr_start.
REQ-037 n_reset asserted during ISSUE -> sfr_start, req_ready fall immediately; after release first request misses.
REQ-038 CACHE_EN=0, two reads of 0x80 -> two sfr_start transactions.
